keypad_divider_seq: RTL and testbench

KEYPAD_DIVIDER_SEQ -- requirements
Module: keypad_divider_seq

---
 rtl/keypad_divider_seq.sv | 196 +++++++++++++++++++
 tb/tb_keypad_divider_seq.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : keypad_divider_seq
// Description : Hex-keypad operand entry followed by an unsigned restoring
//               divider. Two operands of N_DIGITS hex digits are keyed in
//               MSB-first (A then B), then A / B is computed one quotient bit
//               per cycle on internal copies so the operands stay visible.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          : clock, rising-edge
//   rst          : asynchronous active-high reset
//   key_valid    : one-cycle strobe qualifying key_hex
//   key_hex      : hex digit 0x0..0xF
//   clear        : synchronous abort / clear
//   a_bin, b_bin : operand registers as entered
//   quotient     : last quotient
//   remainder    : last remainder
//   busy         : high while dividing
//   done         : one-cycle pulse when a result is written
//   result_valid : results belong to the displayed operands
//   div_by_zero  : last result came from B = 0
//   entry_state  : 0 ENTER_A, 1 ENTER_B, 2 DIVIDE, 3 DONE
// ============================================================================
module keypad_divider_seq #(
  parameter  int N_DIGITS = 2,
  localparam int W        = 4 * N_DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_hex,
  input  logic         clear,
  output logic [W-1:0] a_bin,
  output logic [W-1:0] b_bin,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         result_valid,
  output logic         div_by_zero,
  output logic [1:0]   entry_state
);

  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int BW = $clog2(W);

  localparam logic [CW-1:0] LAST_DIGIT = CW'(N_DIGITS - 1);
  // Counter value meaning "B complete, start the divide on the next edge".
  localparam logic [CW-1:0] B_FULL     = CW'(N_DIGITS);
  localparam logic [BW-1:0] LAST_BIT   = BW'(W - 1);

  typedef enum logic [1:0] {
    S_ENTER_A = 2'd0,
    S_ENTER_B = 2'd1,
    S_DIVIDE  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] dig_cnt;
  logic [BW-1:0] bit_cnt;
  logic [W-1:0]  dvd;   // working dividend, shifts out MSB first, quotient bits shift in
  logic [W-1:0]  dvs;   // divisor copy
  logic [W-1:0]  rem;   // partial remainder

  logic [W-1:0]  a_shift;
  logic [W-1:0]  b_shift;
  logic [W:0]    trial;
  logic          step_ge;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  dvd_next;

  assign a_shift = W'({a_bin, key_hex});
  assign b_shift = W'({b_bin, key_hex});

  // One restoring-division step.
  assign trial    = {rem, dvd[W-1]};
  assign step_ge  = (trial >= {1'b0, dvs});
  assign rem_next = step_ge ? W'(trial - {1'b0, dvs}) : trial[W-1:0];
  assign dvd_next = {dvd[W-2:0], step_ge};

  assign busy        = (state == S_DIVIDE);
  assign entry_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_ENTER_A;
      dig_cnt      <= '0;
      bit_cnt      <= '0;
      dvd          <= '0;
      dvs          <= '0;
      rem          <= '0;
      a_bin        <= '0;
      b_bin        <= '0;
      quotient     <= '0;
      remainder    <= '0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state        <= S_ENTER_A;
        dig_cnt      <= '0;
        bit_cnt      <= '0;
        dvd          <= '0;
        dvs          <= '0;
        rem          <= '0;
        a_bin        <= '0;
        b_bin        <= '0;
        quotient     <= '0;
        remainder    <= '0;
        result_valid <= 1'b0;
        div_by_zero  <= 1'b0;
      end else begin
        case (state)
          S_ENTER_A: begin
            if (key_valid) begin
              a_bin <= a_shift;
              if (dig_cnt == LAST_DIGIT) begin
                dig_cnt <= '0;
                state   <= S_ENTER_B;
              end else begin
                dig_cnt <= dig_cnt + CW'(1);
              end
            end
          end

          S_ENTER_B: begin
            if (dig_cnt == B_FULL) begin
              // Operands complete: one settling cycle, keys are ignored here.
              dig_cnt <= '0;
              if (b_bin == '0) begin
                quotient     <= '0;
                remainder    <= a_bin;
                div_by_zero  <= 1'b1;
                result_valid <= 1'b1;
                done         <= 1'b1;
                state        <= S_DONE;
              end else begin
                dvd     <= a_bin;
                dvs     <= b_bin;
                rem     <= '0;
                bit_cnt <= '0;
                state   <= S_DIVIDE;
              end
            end else if (key_valid) begin
              b_bin <= b_shift;
              if (dig_cnt == LAST_DIGIT) begin
                dig_cnt <= B_FULL;
              end else begin
                dig_cnt <= dig_cnt + CW'(1);
              end
            end
          end

          S_DIVIDE: begin
            dvd <= dvd_next;
            rem <= rem_next;
            if (bit_cnt == LAST_BIT) begin
              // Final step writes the results directly from the step logic.
              quotient     <= dvd_next;
              remainder    <= rem_next;
              div_by_zero  <= 1'b0;
              result_valid <= 1'b1;
              done         <= 1'b1;
              state        <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end

          S_DONE: begin
            if (key_valid) begin
              a_bin        <= W'(key_hex);
              b_bin        <= '0;
              result_valid <= 1'b0;
              if (N_DIGITS == 1) begin
                dig_cnt <= '0;
                state   <= S_ENTER_B;
              end else begin
                dig_cnt <= CW'(1);
                state   <= S_ENTER_A;
              end
            end
          end

          default: state <= S_ENTER_A;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_divider_seq
// Description : Self-checking bench for keypad_divider_seq. Two instances:
//               N_DIGITS=2 and N_DIGITS=4. Expected results are queued when
//               the last divisor digit is keyed and compared on each done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_divider_seq;

  logic clk;
  logic rst;

  logic        kv2, clr2;
  logic [3:0]  kh2;
  logic [7:0]  a2, b2, q2, r2;
  logic        busy2, done2, rv2, dz2;
  logic [1:0]  st2;

  logic        kv4, clr4;
  logic [3:0]  kh4;
  logic [15:0] a4, b4, q4, r4;
  logic        busy4, done4, rv4, dz4;
  logic [1:0]  st4;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  exp_t exp2[$];
  exp_t exp4[$];
  exp_t e2, e4;

  keypad_divider_seq #(.N_DIGITS(2)) u2 (
    .clk(clk), .rst(rst), .key_valid(kv2), .key_hex(kh2), .clear(clr2),
    .a_bin(a2), .b_bin(b2), .quotient(q2), .remainder(r2), .busy(busy2),
    .done(done2), .result_valid(rv2), .div_by_zero(dz2), .entry_state(st2)
  );

  keypad_divider_seq #(.N_DIGITS(4)) u4 (
    .clk(clk), .rst(rst), .key_valid(kv4), .key_hex(kh4), .clear(clr4),
    .a_bin(a4), .b_bin(b4), .quotient(q4), .remainder(r4), .busy(busy4),
    .done(done4), .result_valid(rv4), .div_by_zero(dz4), .entry_state(st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done2) begin
      checks++;
      if (exp2.size() == 0) begin
        errors++;
        $display("FAIL done2_unexpected: got q=%h r=%h dz=%b, required no done", q2, r2, dz2);
      end else begin
        e2 = exp2.pop_front();
        if ({q2, r2, dz2} !== {e2.q[7:0], e2.r[7:0], e2.dz}) begin
          errors++;
          $display("FAIL result2: got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                   q2, r2, dz2, e2.q[7:0], e2.r[7:0], e2.dz);
        end
      end
    end
    if (!rst && done4) begin
      checks++;
      if (exp4.size() == 0) begin
        errors++;
        $display("FAIL done4_unexpected: got q=%h r=%h, required no done", q4, r4);
      end else begin
        e4 = exp4.pop_front();
        if ({q4, r4, dz4} !== {e4.q, e4.r, e4.dz}) begin
          errors++;
          $display("FAIL result4: got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                   q4, r4, dz4, e4.q, e4.r, e4.dz);
        end
      end
    end
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'h0) begin
      e.q = 16'h0; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // All presses start and end on a falling edge; the key is taken at the rising edge between.
  task automatic press2(input logic [3:0] k);
    kv2 = 1'b1; kh2 = k;
    @(posedge clk); @(negedge clk);
    kv2 = 1'b0;
  endtask

  task automatic press4(input logic [3:0] k);
    kv4 = 1'b1; kh4 = k;
    @(posedge clk); @(negedge clk);
    kv4 = 1'b0;
  endtask

  task automatic enter2(input logic [7:0] a, input logic [7:0] b);
    press2(a[7:4]); press2(a[3:0]); press2(b[7:4]); press2(b[3:0]);
  endtask

  task automatic wait_done2(input string name);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (done2) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: got no done in 20 cycles, required done", name);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({a2, b2, q2, r2, busy2, done2, rv2, dz2, st2} !== '0) begin
      errors++;
      $display("FAIL reset2: got a=%h b=%h q=%h r=%h bsy=%b dn=%b rv=%b dz=%b st=%0d, required all 0",
               a2, b2, q2, r2, busy2, done2, rv2, dz2, st2);
    end
    checks++;
    if ({a4, b4, q4, r4, busy4, done4, rv4, dz4, st4} !== '0) begin
      errors++;
      $display("FAIL reset4: got a=%h b=%h q=%h r=%h st=%0d, required all 0", a4, b4, q4, r4, st4);
    end
  endtask

  task automatic test_normal();
    int busy_cnt = 0;
    int done_at  = 0;
    int done_cnt = 0;
    enter2(8'h64, 8'h07);
    exp2.push_back(model(16'h64, 16'h07));
    checks++;
    if (st2 !== 2'd1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL normal_pending: got st=%0d busy=%b, required st=1 busy=0", st2, busy2);
    end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (busy2) busy_cnt++;
      if (done2) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
    end
    checks++;
    if (busy_cnt != 8) begin
      errors++; $display("FAIL normal_busy_cycles: got %0d, required 8", busy_cnt);
    end
    checks++;
    if (done_at != 9 || done_cnt != 1) begin
      errors++; $display("FAIL normal_done_edge: got edge k+%0d count %0d, required k+9 count 1", done_at, done_cnt);
    end
    checks++;
    if ({a2, b2, rv2, dz2, st2} !== {8'h64, 8'h07, 1'b1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL normal_final: got a=%h b=%h rv=%b dz=%b st=%0d, required 64 07 1 0 3", a2, b2, rv2, dz2, st2);
    end
  endtask

  task automatic test_key_in_done();
    press2(4'h3);
    checks++;
    if ({a2, b2, rv2, q2, r2, st2} !== {8'h03, 8'h00, 1'b0, 8'h0E, 8'h02, 2'd0}) begin
      errors++;
      $display("FAIL key_in_done: got a=%h b=%h rv=%b q=%h r=%h st=%0d, required 03 00 0 0e 02 0",
               a2, b2, rv2, q2, r2, st2);
    end
  endtask

  task automatic test_clear_then_key();
    clr2 = 1'b1; kv2 = 1'b1; kh2 = 4'h7;
    @(posedge clk); @(negedge clk);
    clr2 = 1'b0; kv2 = 1'b0;
    checks++;
    if ({a2, b2, q2, r2, rv2, dz2, st2} !== '0) begin
      errors++;
      $display("FAIL clear_with_key: got a=%h b=%h q=%h r=%h rv=%b dz=%b st=%0d, required all 0",
               a2, b2, q2, r2, rv2, dz2, st2);
    end
    // Digit counter must have been cleared: two keys complete A.
    press2(4'h1); press2(4'h2);
    checks++;
    if (a2 !== 8'h12 || st2 !== 2'd1) begin
      errors++; $display("FAIL clear_counter: got a=%h st=%0d, required a=12 st=1", a2, st2);
    end
    clr2 = 1'b1;
    @(posedge clk); @(negedge clk);
    clr2 = 1'b0;
  endtask

  task automatic test_div_zero();
    bit busy_seen;
    enter2(8'h05, 8'h00);
    exp2.push_back(model(16'h05, 16'h00));
    busy_seen = busy2;
    @(negedge clk);
    busy_seen |= busy2;
    checks++;
    if ({done2, dz2, q2, r2, st2, rv2} !== {1'b1, 1'b1, 8'h00, 8'h05, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL div_zero_k1: got done=%b dz=%b q=%h r=%h st=%0d rv=%b, required 1 1 00 05 3 1",
               done2, dz2, q2, r2, st2, rv2);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      busy_seen |= busy2;
    end
    checks++;
    if (busy_seen !== 1'b0) begin
      errors++; $display("FAIL div_zero_busy: got busy=1, required busy never high");
    end
  endtask

  task automatic test_ignore_during_divide();
    enter2(8'hFF, 8'h01);
    exp2.push_back(model(16'hFF, 16'h01));
    @(negedge clk);
    for (int n = 1; n <= 8; n++) begin
      kv2 = 1'b1; kh2 = 4'(n);
      @(negedge clk);
    end
    kv2 = 1'b0;
    checks++;
    if ({a2, b2, q2, r2, st2, done2} !== {8'hFF, 8'h01, 8'hFF, 8'h00, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL ignore_keys: got a=%h b=%h q=%h r=%h st=%0d done=%b, required ff 01 ff 00 3 1",
               a2, b2, q2, r2, st2, done2);
    end
    @(negedge clk);
    checks++;
    if (st2 !== 2'd3 || a2 !== 8'hFF) begin
      errors++; $display("FAIL ignore_not_queued: got st=%0d a=%h, required st=3 a=ff", st2, a2);
    end
  endtask

  task automatic test_clear_mid_divide();
    bit done_seen = 1'b0;
    enter2(8'hC8, 8'h05);
    for (int n = 1; n <= 3; n++) @(negedge clk);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    done_seen = done2;
    checks++;
    if ({a2, b2, q2, r2, rv2, dz2, st2, busy2} !== '0) begin
      errors++;
      $display("FAIL clear_mid: got a=%h b=%h q=%h r=%h rv=%b dz=%b st=%0d busy=%b, required all 0",
               a2, b2, q2, r2, rv2, dz2, st2, busy2);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      done_seen |= done2;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++; $display("FAIL clear_no_done: got done pulse, required none");
    end
  endtask

  task automatic test_rst_mid_divide();
    enter2(8'hE1, 8'h03);
    exp2.push_back(model(16'hE1, 16'h03));
    wait_done2("rst_pre");
    enter2(8'hE1, 8'h03);
    for (int n = 1; n <= 4; n++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({a2, b2, q2, r2, busy2, done2, rv2, dz2, st2} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got a=%h b=%h q=%h r=%h bsy=%b rv=%b st=%0d, required all 0",
               a2, b2, q2, r2, busy2, rv2, st2);
    end
    @(negedge clk);
    rst = 1'b0;
    press2(4'hA);
    checks++;
    if (a2 !== 8'h0A || st2 !== 2'd0) begin
      errors++; $display("FAIL rst_first_key: got a=%h st=%0d, required a=0a st=0", a2, st2);
    end
    clr2 = 1'b1;
    @(posedge clk); @(negedge clk);
    clr2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i == 3) ? 8'h00 : (i == 5) ? 8'hFF : 8'($urandom_range(0, 255));
      enter2(a, b);
      exp2.push_back(model({8'h0, a}, {8'h0, b}));
      wait_done2("b2b");
    end
    @(negedge clk);
    checks++;
    if (exp2.size() != 0) begin
      errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp2.size());
    end
  endtask

  task automatic test_wide();
    int done_at  = 0;
    int busy_cnt = 0;
    press4(4'hF); press4(4'hF); press4(4'hF); press4(4'hF);
    press4(4'h0); press4(4'h1); press4(4'h0); press4(4'h0);
    exp4.push_back(model(16'hFFFF, 16'h0100));
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy4) busy_cnt++;
      if (done4 && done_at == 0) done_at = n;
    end
    checks++;
    if (done_at != 17 || busy_cnt != 16) begin
      errors++; $display("FAIL wide_timing: got done k+%0d busy %0d, required k+17 busy 16", done_at, busy_cnt);
    end
    checks++;
    if ({q4, r4, a4, b4} !== {16'h00FF, 16'h00FF, 16'hFFFF, 16'h0100}) begin
      errors++; $display("FAIL wide_values: got q=%h r=%h a=%h b=%h, required 00ff 00ff ffff 0100", q4, r4, a4, b4);
    end
  endtask

  initial begin
    rst = 1'b1;
    kv2 = 1'b0; kh2 = 4'h0; clr2 = 1'b0;
    kv4 = 1'b0; kh4 = 4'h0; clr4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_normal();
    test_key_in_done();
    test_clear_then_key();
    test_div_zero();
    test_ignore_during_divide();
    test_clear_mid_divide();
    test_rst_mid_divide();
    test_back_to_back();
    test_wide();
    repeat (2) @(negedge clk);
    checks++;
    if (exp2.size() != 0 || exp4.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d/%0d pending, required 0/0", exp2.size(), exp4.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, required finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
